// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the base-SRAM arbiter:
//               FSM state encoding, grant encoding, data width and default
//               SRAM word-address width.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int SRAM_AW_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Bundle of IF-port, MEM-port, stall and SRAM-pad signals.
//               Suffixes are from the arbiter's point of view.
//   slave  : arbiter side (takes requests, drives acks/stalls/SRAM strobes)
//   master : environment side (requesters, pipeline control, SRAM pads)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
  parameter int SRAM_AW = sram_arb_pkg::SRAM_AW_DEFAULT
);
  // Instruction-fetch port (read only)
  logic                           if_req_i;
  logic [31:0]                    if_addr_i;
  logic [sram_arb_pkg::DATA_W-1:0] if_rdata_o;
  logic                           if_ack_o;
  // MEM-stage port
  logic                           mem_req_i;
  logic                           mem_we_i;
  logic [3:0]                     mem_sel_i;
  logic [31:0]                    mem_addr_i;
  logic [sram_arb_pkg::DATA_W-1:0] mem_wdata_i;
  logic [sram_arb_pkg::DATA_W-1:0] mem_rdata_o;
  logic                           mem_ack_o;
  // Pipeline stall requests
  logic                           stall_if_o;
  logic                           stall_mem_o;
  // SRAM pads
  logic [SRAM_AW-1:0]             sram_addr_o;
  logic [sram_arb_pkg::DATA_W-1:0] sram_dq_o;
  logic [sram_arb_pkg::DATA_W-1:0] sram_dq_i;
  logic                           sram_dq_oe_o;
  logic                           sram_ce_n_o;
  logic                           sram_oe_n_o;
  logic                           sram_we_n_o;
  logic [3:0]                     sram_be_n_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ack_o,
    output stall_if_o, stall_mem_o,
    output sram_addr_o, sram_dq_o, sram_dq_oe_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
    input  sram_dq_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ack_o,
    input  stall_if_o, stall_mem_o,
    input  sram_addr_o, sram_dq_o, sram_dq_oe_o,
    input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
    output sram_dq_i
  );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one asynchronous SRAM between instruction fetch (IF)
//               and the MEM stage. One access at a time, MEM has strict
//               priority. Reads hold CE/OE low for RD_CYCLES then capture;
//               writes run setup / WE pulse (WR_CYCLES) / hold. Each access
//               ends with a one-cycle ack in DONE.
// Ports       : clk, rst_n (async, active-low), bus (sram_arbiter_if.slave)
// Parameters  : RD_CYCLES (>=1), WR_CYCLES (>=1), SRAM_AW
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 1,
  parameter int SRAM_AW   = SRAM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);

  localparam int                 MAX_CYC = max2(RD_CYCLES, WR_CYCLES);
  localparam int                 CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]   RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WR_LAST = CNT_W'(WR_CYCLES - 1);

  state_e               state_q, state_d;
  gnt_e                 gnt_q,   gnt_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [3:0]           sel_q,   sel_d;
  logic [SRAM_AW-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]    mem_rdata_q, mem_rdata_d;

  // Byte-offset and upper address bits are intentionally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.if_addr_i[31:SRAM_AW+2], bus.if_addr_i[1:0],
                           bus.mem_addr_i[31:SRAM_AW+2], bus.mem_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      cnt_q       <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state: grant, latch and sequence timing.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.mem_req_i) begin
          gnt_d   = GNT_MEM;
          addr_d  = bus.mem_addr_i[SRAM_AW+1:2];
          sel_d   = bus.mem_sel_i;
          wdata_d = bus.mem_wdata_i;
          state_d = bus.mem_we_i ? ST_WR_SETUP : ST_RD;
        end else if (bus.if_req_i) begin
          gnt_d   = GNT_IF;
          addr_d  = bus.if_addr_i[SRAM_AW+1:2];
          sel_d   = 4'b1111;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          // Data has been stable for RD_CYCLES cycles of OE low.
          if (gnt_q == GNT_IF) if_rdata_d  = bus.sram_dq_i;
          else                 mem_rdata_d = bus.sram_dq_i;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE: begin
        gnt_d   = GNT_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so strobes release as soon as
  // reset forces the state back to IDLE.
  logic       w_ce_n, w_oe_n, w_we_n, w_dq_oe;
  logic [3:0] w_be_n;
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_dq_oe = 1'b0;
    w_be_n  = 4'b1111;
    case (state_q)
      ST_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = ~sel_q;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
        w_be_n  = ~sel_q;
      end
      ST_WR_PULSE: begin
        w_ce_n  = 1'b0;
        w_we_n  = 1'b0;
        w_dq_oe = 1'b1;
        w_be_n  = ~sel_q;
      end
      default: ;
    endcase
  end

  assign bus.sram_ce_n_o  = w_ce_n;
  assign bus.sram_oe_n_o  = w_oe_n;
  assign bus.sram_we_n_o  = w_we_n;
  assign bus.sram_dq_oe_o = w_dq_oe;
  assign bus.sram_be_n_o  = w_be_n;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_dq_o    = wdata_q;

  assign bus.if_ack_o     = (state_q == ST_DONE) && (gnt_q == GNT_IF);
  assign bus.mem_ack_o    = (state_q == ST_DONE) && (gnt_q == GNT_MEM);
  assign bus.if_rdata_o   = if_rdata_q;
  assign bus.mem_rdata_o  = mem_rdata_q;

  // Combinational so the pipeline releases in the ack cycle itself.
  assign bus.stall_if_o   = bus.if_req_i  & ~bus.if_ack_o;
  assign bus.stall_mem_o  = bus.mem_req_i & ~bus.mem_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter. dut_a uses
//               default timing, dut_b uses RD_CYCLES=3 / WR_CYCLES=2. Each
//               DUT has a small behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; sel_b steers requests to dut_b instead of dut_a.
  logic        sel_b = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  sram_arbiter_if #(.SRAM_AW(20)) ia ();
  sram_arbiter_if #(.SRAM_AW(20)) ib ();

  sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(1), .SRAM_AW(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  sram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(2), .SRAM_AW(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  assign ia.if_req_i    = if_req & ~sel_b;
  assign ia.if_addr_i   = if_addr;
  assign ia.mem_req_i   = mem_req & ~sel_b;
  assign ia.mem_we_i    = mem_we;
  assign ia.mem_sel_i   = mem_sel;
  assign ia.mem_addr_i  = mem_addr;
  assign ia.mem_wdata_i = mem_wdata;
  assign ib.if_req_i    = if_req & sel_b;
  assign ib.if_addr_i   = if_addr;
  assign ib.mem_req_i   = mem_req & sel_b;
  assign ib.mem_we_i    = mem_we;
  assign ib.mem_sel_i   = mem_sel;
  assign ib.mem_addr_i  = mem_addr;
  assign ib.mem_wdata_i = mem_wdata;

  // Asynchronous SRAM models: read data only while CE and OE are low.
  assign ia.sram_dq_i = (!ia.sram_ce_n_o && !ia.sram_oe_n_o) ? mem_a[ia.sram_addr_o[7:0]] : 32'h0;
  assign ib.sram_dq_i = (!ib.sram_ce_n_o && !ib.sram_oe_n_o) ? mem_b[ib.sram_addr_o[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!ia.sram_ce_n_o && !ia.sram_we_n_o && ia.sram_dq_oe_o)
      for (int b = 0; b < 4; b++)
        if (!ia.sram_be_n_o[b]) mem_a[ia.sram_addr_o[7:0]][8*b +: 8] <= ia.sram_dq_o[8*b +: 8];
    if (!ib.sram_ce_n_o && !ib.sram_we_n_o && ib.sram_dq_oe_o)
      for (int b = 0; b < 4; b++)
        if (!ib.sram_be_n_o[b]) mem_b[ib.sram_addr_o[7:0]][8*b +: 8] <= ib.sram_dq_o[8*b +: 8];
  end

  // Observed signals of whichever DUT is selected.
  logic        w_ce_n, w_oe_n, w_we_n, w_dq_oe, w_if_ack, w_mem_ack, w_stall_if, w_stall_mem;
  logic [3:0]  w_be_n;
  logic [19:0] w_addr;
  logic [31:0] w_dq_o, w_if_rdata, w_mem_rdata;
  assign w_ce_n      = sel_b ? ib.sram_ce_n_o  : ia.sram_ce_n_o;
  assign w_oe_n      = sel_b ? ib.sram_oe_n_o  : ia.sram_oe_n_o;
  assign w_we_n      = sel_b ? ib.sram_we_n_o  : ia.sram_we_n_o;
  assign w_dq_oe     = sel_b ? ib.sram_dq_oe_o : ia.sram_dq_oe_o;
  assign w_be_n      = sel_b ? ib.sram_be_n_o  : ia.sram_be_n_o;
  assign w_addr      = sel_b ? ib.sram_addr_o  : ia.sram_addr_o;
  assign w_dq_o      = sel_b ? ib.sram_dq_o    : ia.sram_dq_o;
  assign w_if_ack    = sel_b ? ib.if_ack_o     : ia.if_ack_o;
  assign w_mem_ack   = sel_b ? ib.mem_ack_o    : ia.mem_ack_o;
  assign w_if_rdata  = sel_b ? ib.if_rdata_o   : ia.if_rdata_o;
  assign w_mem_rdata = sel_b ? ib.mem_rdata_o  : ia.mem_rdata_o;
  assign w_stall_if  = sel_b ? ib.stall_if_o   : ia.stall_if_o;
  assign w_stall_mem = sel_b ? ib.stall_mem_o  : ia.stall_mem_o;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access; cycle 0 is the IDLE cycle in which the request is first seen.
  task automatic do_access(
    input  bit          use_b, is_if, we,
    input  logic [3:0]  sel,
    input  logic [31:0] addr, wdata,
    output int          ack_cyc, we_first, we_cnt, oe_first, oe_cnt, dq_oe_cnt, stall_cnt,
    output logic [3:0]  be1,
    output logic [19:0] addr1,
    output logic [31:0] rdata
  );
    @(negedge clk);
    sel_b = use_b;
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata; mem_req = 1'b1;
    end
    ack_cyc = -1; we_first = -1; we_cnt = 0; oe_first = -1; oe_cnt = 0;
    dq_oe_cnt = 0; stall_cnt = 0; be1 = 'x; addr1 = 'x; rdata = 'x;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (!w_we_n) begin if (we_first < 0) we_first = c; we_cnt++; end
      if (!w_oe_n) begin if (oe_first < 0) oe_first = c; oe_cnt++; end
      if (w_dq_oe) dq_oe_cnt++;
      if (is_if ? w_stall_if : w_stall_mem) stall_cnt++;
      if (c == 1) begin be1 = w_be_n; addr1 = w_addr; end
      if (is_if ? w_if_ack : w_mem_ack) begin
        ack_cyc = c;
        rdata = is_if ? w_if_rdata : w_mem_rdata;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  int ack, wf, wc, of, oc, dc, sc;
  logic [3:0]  be1;
  logic [19:0] ad1;
  logic [31:0] rd;
  int mack, iack, stall_last, a1, a2, ack_seen;
  logic [31:0] mrd, ird, rd1, rd2;
  logic [19:0] addr5;
  logic        ack_after;

  initial begin
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[0] = 32'h0101_0101;
    mem_a[1] = 32'h0202_0202;
    mem_a[2] = 32'hCAFE_F00D;
    mem_a[4] = 32'hDEAD_BEEF;
    mem_b[4] = 32'h0BAD_F00D;

    // Reset state
    #7;
    check("rst ce_n", 32'(w_ce_n), 32'd1);
    check("rst oe_n", 32'(w_oe_n), 32'd1);
    check("rst we_n", 32'(w_we_n), 32'd1);
    check("rst be_n", 32'(w_be_n), 32'hF);
    check("rst dq_oe", 32'(w_dq_oe), 32'd0);
    check("rst addr", 32'(w_addr), 32'd0);
    check("rst dq_o", w_dq_o, 32'd0);
    check("rst acks", {30'd0, w_if_ack, w_mem_ack}, 32'd0);
    check("rst rdata", w_if_rdata | w_mem_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // IF read of word 4
    do_access(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, ack, wf, wc, of, oc, dc, sc, be1, ad1, rd);
    check("ifrd addr", 32'(ad1), 32'd4);
    check("ifrd oe_first", of, 1);
    check("ifrd oe_cnt", oc, 2);
    check("ifrd ack_cyc", ack, 3);
    check("ifrd rdata", rd, 32'hDEAD_BEEF);
    check("ifrd stall_cnt", sc, 3);

    // MEM byte write
    do_access(1'b0, 1'b0, 1'b1, 4'b1000, 32'h103, 32'h1122_3344, ack, wf, wc, of, oc, dc, sc, be1, ad1, rd);
    check("wr addr", 32'(ad1), 32'h40);
    check("wr be_n", 32'(be1), 32'b0111);
    check("wr we_first", wf, 2);
    check("wr we_cnt", wc, 1);
    check("wr dq_oe_cnt", dc, 3);
    check("wr ack_cyc", ack, 4);
    check("wr sram", mem_a[8'h40], 32'h1100_0000);

    // Collision: MEM read 0x8 and IF read 0x10 together
    @(negedge clk);
    sel_b = 1'b0;
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8; mem_req = 1'b1;
    if_addr = 32'h10; if_req = 1'b1;
    mack = -1; iack = -1; stall_last = -1; addr5 = 'x; mrd = 'x; ird = 'x;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (w_stall_if) stall_last = c;
      if (c == 5) addr5 = w_addr;
      if (w_mem_ack) begin mack = c; mrd = w_mem_rdata; mem_req = 1'b0; end
      if (w_if_ack) begin iack = c; ird = w_if_rdata; if_req = 1'b0; break; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("col mem_ack", mack, 3);
    check("col if_ack", iack, 7);
    check("col stall_if last", stall_last, 6);
    check("col if addr", 32'(addr5), 32'd4);
    check("col mem_rdata", mrd, 32'hCAFE_F00D);
    check("col if_rdata", ird, 32'hDEAD_BEEF);

    // Slow-timing instance: read then write
    do_access(1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, ack, wf, wc, of, oc, dc, sc, be1, ad1, rd);
    check("b rd ack_cyc", ack, 4);
    check("b rd oe_cnt", oc, 3);
    check("b rd rdata", rd, 32'h0BAD_F00D);
    do_access(1'b1, 1'b0, 1'b1, 4'b0011, 32'h20, 32'h5566_7788, ack, wf, wc, of, oc, dc, sc, be1, ad1, rd);
    check("b wr ack_cyc", ack, 5);
    check("b wr we_first", wf, 2);
    check("b wr we_cnt", wc, 2);
    check("b wr sram", mem_b[8], 32'h0000_7788);

    // Reset during WR_PULSE, request held through reset release
    @(negedge clk);
    sel_b = 1'b0;
    mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h20; mem_wdata = 32'hA5A5_5A5A; mem_req = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("rstw pulse we_n", 32'(w_we_n), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw we_n", 32'(w_we_n), 32'd1);
    check("rstw dq_oe", 32'(w_dq_oe), 32'd0);
    check("rstw ce_n", 32'(w_ce_n), 32'd1);
    check("rstw state", 32'(dut_a.state_q), 32'(ST_IDLE));
    ack_seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      if (w_mem_ack) ack_seen++;
    end
    check("rstw no ack", ack_seen, 0);
    check("rstw sram untouched", mem_a[8], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ack = -1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (w_mem_ack) begin ack = c; mem_req = 1'b0; break; end
    end
    mem_req = 1'b0;
    check("rstw retry ack", ack, 4);
    check("rstw retry sram", mem_a[8], 32'hA5A5_5A5A);

    // Back-to-back MEM reads 0x0 then 0x4
    @(negedge clk);
    sel_b = 1'b0;
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0; mem_req = 1'b1;
    a1 = -1; a2 = -1; ack_after = 1'bx; rd1 = 'x; rd2 = 'x;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (a1 >= 0 && c == a1 + 1) ack_after = w_mem_ack;
      if (w_mem_ack) begin
        if (a1 < 0) begin
          a1 = c; rd1 = w_mem_rdata; mem_addr = 32'h4;
        end else begin
          a2 = c; rd2 = w_mem_rdata; mem_req = 1'b0; break;
        end
      end
    end
    mem_req = 1'b0;
    check("b2b ack1", a1, 3);
    check("b2b ack pulse", 32'(ack_after), 32'd0);
    check("b2b ack2", a2, 7);
    check("b2b rdata1", rd1, 32'h0101_0101);
    check("b2b rdata2", rd2, 32'h0202_0202);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single base SRAM between instruction fetch and the MEM stage. Accepts one request at a time, gives MEM strict priority over IF, and sequences the asynchronous SRAM through multi-cycle read and write timing. Raises per-requester stall requests to the pipeline controller until each access completes. Sits between IF/MEM and the external SRAM pins.

## Interface
- RD_CYCLES, 2, cycles OE/CE held low before read data is captured (≥1)
- WR_CYCLES, 1, cycles WE held low during a write (≥1)
- SRAM_AW, 20, SRAM word-address width
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  IF read request, held until if_ack
- if_addr  in  32  IF byte address
- if_rdata  out  32  IF read data, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse to IF
- mem_req  in  1  MEM request (the MEM stage's chip enable), held until mem_ack
- mem_we  in  1  1 = write, 0 = read
- mem_sel  in  4  byte select, active-high
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  MEM write data
- mem_rdata  out  32  MEM read data, valid when mem_ack=1
- mem_ack  out  1  one-cycle completion pulse to MEM
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  mem_req & ~mem_ack
- sram_addr  out  SRAM_AW  word address = latched addr[SRAM_AW+1:2]
- sram_dq_o  out  32  write data to pad
- sram_dq_i  in  32  read data from pad
- sram_dq_oe  out  1  pad output enable
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- sram_be_n  out  4  active-low byte enables

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: if mem_req, grant MEM; else if if_req, grant IF; else stay. On grant, latch addr, wdata, sel, we (IF is always a read with sel=4'b1111). Go to RD if read, else WR_SETUP.
- RD: ce_n=0, oe_n=0, dq_oe=0. The counter runs RD_CYCLES cycles. On the last cycle, capture sram_dq_i into the grantee's rdata register. Go to DONE.
- WR_SETUP: one cycle; ce_n=0, we_n=1, dq_oe=1, address and data driven.
- WR_PULSE: WR_CYCLES cycles; we_n=0.
- WR_HOLD: one cycle; we_n=1, data and address still driven.
- DONE: one cycle; assert the grantee's ack and drop all strobes. Next state is IDLE. Requests are not sampled in DONE.
- sram_be_n = ~latched sel during RD and write states. It is 4'b1111 when idle.
- Outside an access, strobes are 1 and dq_oe=0. rdata registers hold their value until the next capture for that requester.
- A requester must keep req, addr and data stable until it sees ack. In the cycle after ack it either drops req or presents a new request.
- Simultaneous if_req and mem_req: MEM is served first. IF is served on the next IDLE cycle.
- mem_addr bits outside [SRAM_AW+1:2] are ignored. No alignment check is performed.

## Timing
- Reset (rst=0, async): state=IDLE; ce_n=oe_n=we_n=1; be_n=4'hF; dq_oe=0; sram_addr=0; sram_dq_o=0; if_ack=mem_ack=0; if_rdata=mem_rdata=0. stall_* follow their combinational definition.
- Reset mid-write releases we_n immediately. The access is abandoned and no ack is issued.
- The request is seen in IDLE at cycle 0.
  - Read ack is high in cycle RD_CYCLES+1 (3 by default).
  - Write ack is high in cycle WR_CYCLES+3 (4 by default).
- Minimum spacing between two accepted requests = access length + 1 (the IDLE cycle).
- stall_if and stall_mem are combinational from req and ack, so the pipeline releases in the ack cycle.
- All registered outputs change only on the clk rising edge, except on reset.

## Structure
- Shared package sram_arb_pkg holds:
  - state enumeration (3-bit encoding);
  - grant enumeration GNT_NONE, GNT_IF, GNT_MEM;
  - SRAM data width 32 and default SRAM_AW.
- Single module. The RD/WR_PULSE counter is inline, width $clog2(max(RD_CYCLES, WR_CYCLES)+1). No sub-module.

## Test plan
- IF read only: if_addr=0x0000_0010, SRAM word 4 = 0xDEADBEEF → sram_addr=4, oe_n low cycles 1–2, if_ack in cycle 3, if_rdata=0xDEADBEEF, stall_if low from cycle 3.
- MEM byte write: mem_addr=0x0000_0103, sel=4'b1000, wdata=0x11223344 → sram_addr=0x40, be_n=4'b0111, we_n low exactly cycle 2, mem_ack in cycle 4.
- Collision: if_req and mem_req (read 0x8) raised together → MEM is served first (mem_ack cycle 3), IF is accepted at cycle 4 (if_ack cycle 7), and stall_if stays high through cycle 6.
- Parameter sweep RD_CYCLES=3, WR_CYCLES=2 → read ack at cycle 4, write ack at cycle 5, we_n low for 2 cycles.
- Reset during WR_PULSE → we_n=1 and dq_oe=0 immediately, no mem_ack, state IDLE. A request held through reset release is re-accepted and completes normally.
- Back-to-back MEM reads at 0x0 then 0x4 → second access accepted in the IDLE cycle after the first ack. Each mem_ack is a single-cycle pulse.
